// File: rtl/c5g_housekeeping_ext_int_ctrl.sv
// Housekeeping external interrupt controller: synchronises, glitch-filters and
// edge-captures active-low pins, with an Avalon-MM register file and a level IRQ.
module c5g_housekeeping_ext_int_ctrl #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_CNT  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CNT_W = (FILTER_CNT > 1) ? $clog2(FILTER_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CNT - 1);

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_r  [WIDTH];
    logic [WIDTH-1:0] filt_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] capture_r;
    logic [WIDTH-1:0] edge_sel_r;
    logic [31:0]      readdata_r;
    logic             irq_r;

    logic [WIDTH-1:0] sync_out_s;
    logic [WIDTH-1:0] expire_s;
    logic [WIDTH-1:0] set_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] capture_next_s;
    logic [31:0]      rd_mux_s;
    logic             wr_s;
    logic             unused_wdata_s;

    assign sync_out_s     = sync_r[SYNC_STAGES-1];
    assign wr_s           = chipselect & ~write_n;
    assign unused_wdata_s = ^writedata;
    assign readdata       = readdata_r;
    assign irq            = irq_r;

    // Synchroniser chain; idles at 1 so an unplugged/high pin never fires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= '1;
            end
        end else begin
            sync_r[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    // A channel's filtered level flips on the edge its stability count completes.
    always_comb begin
        expire_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if ((sync_out_s[i] != filt_r[i]) && (cnt_r[i] == CNT_MAX)) begin
                expire_s[i] = 1'b1;
            end else begin
                expire_s[i] = 1'b0;
            end
        end
    end

    // Edge selection, write-1-to-clear, and set-over-clear priority for CAPTURE.
    always_comb begin
        set_s = (expire_s & filt_r & ~edge_sel_r) | (expire_s & ~filt_r & edge_sel_r);
        if (wr_s && (address == 2'd2)) begin
            clr_s = writedata[WIDTH-1:0];
        end else begin
            clr_s = '0;
        end
        capture_next_s = (capture_r & ~clr_s) | set_s;
    end

    // Glitch filter: any sample equal to the current level discards a partial count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_r <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_out_s[i] == filt_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == CNT_MAX) begin
                    filt_r[i] <= sync_out_s[i];
                    cnt_r[i]  <= '0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

    // Register read mux; unused upper bits read as zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            2'd0:    rd_mux_s[WIDTH-1:0] = filt_r;
            2'd1:    rd_mux_s[WIDTH-1:0] = mask_r;
            2'd2:    rd_mux_s[WIDTH-1:0] = capture_r;
            2'd3:    rd_mux_s[WIDTH-1:0] = edge_sel_r;
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Software registers, CAPTURE, and registered outputs. irq uses the new
    // capture value but the pre-write mask, so a mask write shows one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_r     <= '0;
            edge_sel_r <= '0;
            capture_r  <= '0;
            readdata_r <= 32'd0;
            irq_r      <= 1'b0;
        end else begin
            if (wr_s && (address == 2'd1)) begin
                mask_r <= writedata[WIDTH-1:0];
            end
            if (wr_s && (address == 2'd3)) begin
                edge_sel_r <= writedata[WIDTH-1:0];
            end
            capture_r  <= capture_next_s;
            readdata_r <= rd_mux_s;
            irq_r      <= |(capture_next_s & mask_r);
        end
    end

endmodule
